// File: rtl/axi_512_to_1024.sv
// axi_512_to_1024: packs pairs of 512-bit stream beats into one 1024-bit beat.
// Optional packet counter output enabled by AXI_512_TO_1024_PKT_CNT_EN.
module axi_512_to_1024 (
    input  logic          clk,
    input  logic          rst_n,
    output logic          in_ready,
    input  logic [511:0]  in_data,
    input  logic [63:0]   in_keep,
    input  logic          in_valid,
    input  logic          in_last,
    input  logic          out_ready,
    output logic [1023:0] out_data,
    output logic [127:0]  out_keep,
    output logic          out_valid,
`ifdef AXI_512_TO_1024_PKT_CNT_EN
    output logic          out_last,
    output logic [31:0]   pkt_cnt
`else
    output logic          out_last
`endif
);

    typedef enum logic {
        UPPER = 1'b0,
        LOWER = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [511:0]  hold_q, hold_d;
    logic [63:0]   hold_keep_q, hold_keep_d;
    logic [1023:0] out_data_q, out_data_d;
    logic [127:0]  out_keep_q, out_keep_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          accept;
    logic          consume;

    assign in_ready  = ~out_valid_q | out_ready;
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid_q & out_ready;

    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

    // Next-state: hold upper half, or emit a packed beat on completion
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_keep_d = hold_keep_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (consume) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            unique case (state_q)
                UPPER: begin
                    if (in_last) begin
                        out_data_d  = {in_data, 512'd0};
                        out_keep_d  = {in_keep, 64'd0};
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b1;
                    end else begin
                        hold_d      = in_data;
                        hold_keep_d = in_keep;
                        state_d     = LOWER;
                    end
                end
                LOWER: begin
                    out_data_d  = {hold_q, in_data};
                    out_keep_d  = {hold_keep_q, in_keep};
                    out_valid_d = 1'b1;
                    out_last_d  = in_last;
                    state_d     = UPPER;
                end
                default: begin
                    state_d = UPPER;
                end
            endcase
        end
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= UPPER;
            hold_q      <= '0;
            hold_keep_q <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_keep_q <= hold_keep_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

`ifdef AXI_512_TO_1024_PKT_CNT_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d;

    assign pkt_cnt = pkt_cnt_q;

    // Count consumed end-of-packet beats, wrapping naturally
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (consume && out_last_q) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
        end
    end

    // Packet counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end
`endif

endmodule
